// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   Receive-only PS/2 keyboard front end. Synchronizes and de-glitches the raw
//   PS/2 clock and data pins, deframes 11-bit device-to-host frames, and turns
//   prefixed scancode sequences (E0 / F0) into one toggle-strobe key word.
//
//   Parameters:
//     FILTER_LEN  consecutive clk cycles the synchronized PS/2 clock must
//                 disagree with the filtered clock before it flips (2..255)
//     TIMEOUT     clk cycles allowed between filtered falls inside a frame
//                 before the frame is abandoned (16..65535)
//
//   Ports:
//     clk         system clock, rising edge
//     reset_n     asynchronous active-low reset
//     ps2_clk_i   raw PS/2 clock pin (asynchronous)
//     ps2_data_i  raw PS/2 data pin (asynchronous)
//     ps2_key     [10] toggles per key event, [9] pressed, [8] extended,
//                 [7:0] scancode; holds between events
//     parity_err  one-cycle pulse for a frame failing odd parity
//
//   Build option:
//     PS2_PARITY_CHECK_EN  when defined, frames with bad odd parity are
//                          discarded and flagged on parity_err; when undefined
//                          the parity slot is consumed but its value ignored
//                          and parity_err is tied low.

module ps2_key_decoder #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 20000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ps2_clk_i,
    input  logic        ps2_data_i,
    output logic [10:0] ps2_key,
    output logic        parity_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic        clk_sync_p0;
    logic        clk_sync_p1;
    logic        data_sync_p0;
    logic        data_sync_p1;

    logic        fclk;
    logic [7:0]  flt_cnt;
    logic        flt_flip;
    logic        fall;

    logic [15:0] to_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_q;
    logic        ext_q;
    logic        brk_q;

    logic        stop_fall;
    logic        frame_good;
    logic        stop_bad;
    logic        par_fail;
    logic        byte_accept;
    logic        timeout_hit;
    logic        clear_flags;

`ifdef PS2_PARITY_CHECK_EN
    logic        par_q;
`endif

    // Keyboard housekeeping responses (ACK, BAT result, echo, errors) that
    // must never reach the key-mapping logic.
    function automatic logic is_filler(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_filler = 1'b1;
            default:                                         is_filler = 1'b0;
        endcase
    endfunction

    // ---- stage p0/p1: two-flop synchronizers, idle-high ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_p0  <= 1'b1;
            clk_sync_p1  <= 1'b1;
            data_sync_p0 <= 1'b1;
            data_sync_p1 <= 1'b1;
        end else begin
            clk_sync_p0  <= ps2_clk_i;
            clk_sync_p1  <= clk_sync_p0;
            data_sync_p0 <= ps2_data_i;
            data_sync_p1 <= data_sync_p0;
        end
    end

    // ---- clock filter: fclk flips only after FILTER_LEN disagreeing cycles ----
    assign flt_flip = (clk_sync_p1 != fclk) && (flt_cnt == 8'(FILTER_LEN - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fclk    <= 1'b1;
            flt_cnt <= 8'd0;
            fall    <= 1'b0;
        end else begin
            // fall is high in the first cycle fclk reads 0
            fall <= flt_flip && fclk;
            if (clk_sync_p1 == fclk) begin
                flt_cnt <= 8'd0;
            end else if (flt_flip) begin
                fclk    <= clk_sync_p1;
                flt_cnt <= 8'd0;
            end else begin
                flt_cnt <= flt_cnt + 8'd1;
            end
        end
    end

    // ---- frame FSM: state register ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // ---- frame FSM: next state ----
    always_comb begin
        state_d = state_q;
        if (fall) begin
            case (state_q)
                S_IDLE:   if (!data_sync_p1) state_d = S_DATA;
                S_DATA:   if (bit_cnt == 3'd7) state_d = S_PARITY;
                S_PARITY: state_d = S_STOP;
                S_STOP:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end else if (timeout_hit) begin
            state_d = S_IDLE;
        end
    end

    // ---- frame FSM: decode of frame-completion events ----
    always_comb begin
        stop_fall   = fall && (state_q == S_STOP);
        frame_good  = stop_fall && data_sync_p1;
        stop_bad    = stop_fall && !data_sync_p1;
`ifdef PS2_PARITY_CHECK_EN
        par_fail    = frame_good && !(^{shift_q, par_q});
`else
        par_fail    = 1'b0;
`endif
        byte_accept = frame_good && !par_fail;
        // a fall in the same cycle wins over the timeout
        timeout_hit = (state_q != S_IDLE) && !fall && (to_cnt == 16'(TIMEOUT));
        clear_flags = stop_bad || par_fail || timeout_hit;
    end

    // ---- inter-fall timeout counter ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                         to_cnt <= 16'd0;
        else if (fall || state_q == S_IDLE)   to_cnt <= 16'd0;
        else                                  to_cnt <= to_cnt + 16'd1;
    end

    // ---- deframing datapath (no reset: fully rewritten every frame) ----
    always_ff @(posedge clk) begin
        if (fall && state_q == S_DATA) shift_q <= {data_sync_p1, shift_q[7:1]};
`ifdef PS2_PARITY_CHECK_EN
        if (fall && state_q == S_PARITY) par_q <= data_sync_p1;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt <= 3'd0;
        end else if (fall) begin
            if (state_q == S_IDLE)      bit_cnt <= 3'd0;
            else if (state_q == S_DATA) bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // ---- byte handling: prefix flags and key word ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            ps2_key    <= 11'h000;
            parity_err <= 1'b0;
        end else begin
            parity_err <= par_fail;
            if (byte_accept) begin
                if (shift_q == 8'hE0) begin
                    ext_q <= 1'b1;
                end else if (shift_q == 8'hF0) begin
                    brk_q <= 1'b1;
                end else if (is_filler(shift_q)) begin
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                end else begin
                    ps2_key <= {~ps2_key[10], ~brk_q, ext_q, shift_q};
                    ext_q   <= 1'b0;
                    brk_q   <= 1'b0;
                end
            end else if (clear_flags) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder
//   Directed bench for ps2_key_decoder. Drives PS/2 frames on the raw pins
//   at a slow bit rate and compares ps2_key / parity_err against hand-derived
//   constants. Works with PS2_PARITY_CHECK_EN either defined or undefined.

module tb_ps2_key_decoder;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 1000;
    localparam int HALF       = 20;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk_i = 1'b1;
    logic        ps2_data_i = 1'b1;
    logic [10:0] ps2_key;
    logic        parity_err;

    int errors = 0;
    int checks = 0;
    int perr_cycles = 0;
    int perr_start;

    ps2_key_decoder #(
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ps2_clk_i (ps2_clk_i),
        .ps2_data_i(ps2_data_i),
        .ps2_key   (ps2_key),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (parity_err) perr_cycles <= perr_cycles + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bit(input logic b);
        ps2_data_i = b;
        wait_clk(HALF);
        ps2_clk_i = 1'b0;
        wait_clk(HALF);
        ps2_clk_i = 1'b1;
    endtask

    // start, 8 data LSB-first, parity (odd unless par_bad), stop
    task automatic send_frame(input logic [7:0] b, input logic par_bad, input logic stop);
        logic par;
        par = ~(^b) ^ par_bad;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(stop);
        ps2_data_i = 1'b1;
        wait_clk(40);
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1);
    endtask

    initial begin
        // reset state
        wait_clk(5);
        @(negedge clk);
        check("reset_key", 32'(ps2_key), 32'h000);
        check("reset_perr", 32'(parity_err), 32'h0);
        reset_n = 1'b1;
        wait_clk(5);

        // plain make code
        send_byte(8'h1C);
        check("make_1c", 32'(ps2_key), 32'h61C);

        // extended break: prefixes produce no event
        send_byte(8'hE0);
        check("after_e0", 32'(ps2_key), 32'h61C);
        send_byte(8'hF0);
        check("after_f0", 32'(ps2_key), 32'h61C);
        send_byte(8'h75);
        check("ext_break_75", 32'(ps2_key), 32'h175);
        send_byte(8'h75);
        check("flags_cleared_75", 32'(ps2_key), 32'h675);

        // parity error frame
        perr_start = perr_cycles;
        send_frame(8'h29, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        check("perr_pulse_len", 32'(perr_cycles - perr_start), 32'd1);
        check("perr_key_hold", 32'(ps2_key), 32'h675);
`else
        check("perr_pulse_len", 32'(perr_cycles - perr_start), 32'd0);
        check("perr_ignored_key", 32'(ps2_key), 32'h229);
`endif

        // reset in the middle of a frame
        for (int i = 0; i < 6; i++) send_bit(i[0]);
        reset_n = 1'b0;
        ps2_data_i = 1'b1;
        wait_clk(3);
        @(negedge clk);
        check("midreset_key", 32'(ps2_key), 32'h000);
        check("midreset_perr", 32'(parity_err), 32'h0);
        @(posedge clk);
        reset_n = 1'b1;
        wait_clk(5);
        send_byte(8'h1E);
        check("post_reset_1e", 32'(ps2_key), 32'h61E);

        // timeout discards partial frame and pending F0
        send_byte(8'hF0);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        ps2_data_i = 1'b1;
        wait_clk(TIMEOUT + 10);
        send_byte(8'h29);
        check("timeout_29", 32'(ps2_key), 32'h229);

        // short low glitch on clock with data low must not start a frame
        ps2_data_i = 1'b0;
        wait_clk(4);
        ps2_clk_i = 1'b0;
        wait_clk(FILTER_LEN - 1);
        ps2_clk_i = 1'b1;
        wait_clk(4);
        ps2_data_i = 1'b1;
        wait_clk(30);
        @(negedge clk);
        check("glitch_no_event", 32'(ps2_key), 32'h229);
        send_byte(8'h16);
        check("after_glitch_16", 32'(ps2_key), 32'h616);

        // prefixes in reverse order
        send_byte(8'hF0);
        send_byte(8'hE0);
        send_byte(8'h74);
        check("f0_e0_74", 32'(ps2_key), 32'h174);

        // filler byte clears a pending prefix without an event
        send_byte(8'hF0);
        send_byte(8'hAA);
        check("filler_no_event", 32'(ps2_key), 32'h174);
        send_byte(8'h74);
        check("filler_clears_74", 32'(ps2_key), 32'h674);

        // bad stop bit discards byte and clears prefix
        send_byte(8'hF0);
        send_frame(8'h33, 1'b0, 1'b0);
        check("badstop_no_event", 32'(ps2_key), 32'h674);
        send_byte(8'h74);
        check("badstop_clears_74", 32'(ps2_key), 32'h274);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
